// File: rtl/controle_jogada_timeout_pkg.sv
// rtl/controle_jogada_timeout_pkg.sv - shared exp4 state codes and timing constants
package controle_jogada_timeout_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 3000;
  localparam int TIMER_W_DEF        = 12;

  // Codes are also decoded by the datapath debug displays; keep them stable.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

endpackage

// File: rtl/temporizador_timeout.sv
// rtl/temporizador_timeout.sv - play timeout counter, flags the last allowed cycle
module temporizador_timeout
  import controle_jogada_timeout_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMER_W        = TIMER_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_tempo
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (zera) begin
      count_d = '0;
    end else if (conta && (count_q != {TIMER_W{1'b1}})) begin
      // saturate rather than wrap so a stuck count can never re-arm the timeout
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim_tempo = (count_q == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/controle_jogada_timeout.sv
// rtl/controle_jogada_timeout.sv - Moore control unit for one game round with play timeout
module controle_jogada_timeout
  import controle_jogada_timeout_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMER_W        = TIMER_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       fim,
  input  logic       igual,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       timeout,
  output logic       db_tem_jogada,
  output logic [3:0] db_estado
);

  estado_t estado_q;
  estado_t estado_d;
  logic    db_tem_jogada_q;
  logic    db_tem_jogada_d;
  logic    timer_zera;
  logic    timer_conta;
  logic    fim_tempo;

  temporizador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_temporizador (
    .clock    (clock),
    .reset    (reset),
    .zera     (timer_zera),
    .conta    (timer_conta),
    .fim_tempo(fim_tempo)
  );

  always_comb begin
    estado_d    = estado_q;
    zeraC       = 1'b0;
    contaC      = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    pronto      = 1'b0;
    timeout     = 1'b0;
    timer_zera  = 1'b0;
    timer_conta = 1'b0;
    case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARACAO;
      PREPARACAO: begin
        zeraC      = 1'b1;
        zeraR      = 1'b1;
        timer_zera = 1'b1;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        timer_conta = 1'b1;
        // a play landing on the expiry cycle still counts
        if (jogada)         estado_d = REGISTRA;
        else if (fim_tempo) estado_d = FIM_TIMEOUT;
      end
      REGISTRA: begin
        registraR = 1'b1;
        estado_d  = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)   estado_d = FIM_ERRO;
        else if (fim) estado_d = FIM_ACERTO;
        else          estado_d = PROXIMO;
      end
      PROXIMO: begin
        contaC     = 1'b1;
        timer_zera = 1'b1;
        estado_d   = ESPERA;
      end
      FIM_ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
        if (iniciar) estado_d = PREPARACAO;
      end
      FIM_ERRO: begin
        errou  = 1'b1;
        pronto = 1'b1;
        if (iniciar) estado_d = PREPARACAO;
      end
      FIM_TIMEOUT: begin
        errou   = 1'b1;
        pronto  = 1'b1;
        timeout = 1'b1;
        if (iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign db_tem_jogada_d = jogada;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q        <= INICIAL;
      db_tem_jogada_q <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      db_tem_jogada_q <= db_tem_jogada_d;
    end
  end

  assign db_tem_jogada = db_tem_jogada_q;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_controle_jogada_timeout.sv
// tb/tb_controle_jogada_timeout.sv - randomized and directed bench against a reference model
module tb_controle_jogada_timeout;

  localparam int TO = 3000;

  logic clock, reset, iniciar, jogada, fim, igual;
  logic zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout, db_tem_jogada;
  logic [3:0] db_estado;
  logic [12:0] obs;

  int checks = 0;
  int errors = 0;

  // reference model: game phase code, cycles spent waiting, last sampled play
  int   m_code;
  int   m_wait;
  logic m_db;

  controle_jogada_timeout dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .jogada       (jogada),
    .fim          (fim),
    .igual        (igual),
    .zeraC        (zeraC),
    .contaC       (contaC),
    .zeraR        (zeraR),
    .registraR    (registraR),
    .acertou      (acertou),
    .errou        (errou),
    .pronto       (pronto),
    .timeout      (timeout),
    .db_tem_jogada(db_tem_jogada),
    .db_estado    (db_estado)
  );

  assign obs = {zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout,
                db_tem_jogada, db_estado};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [12:0] exp_obs();
    logic [3:0] c;
    logic fin;
    c   = 4'(m_code);
    fin = (m_code == 10) || (m_code == 13) || (m_code == 14);
    return {m_code == 1, m_code == 6, m_code == 1, m_code == 4, m_code == 10,
            (m_code == 13) || (m_code == 14), fin, m_code == 13, m_db, c};
  endfunction

  task automatic model_reset();
    m_code = 0;
    m_wait = 0;
    m_db   = 1'b0;
  endtask

  task automatic model_step(input logic ini, input logic jog, input logic f, input logic ig);
    int n;
    n = m_code;
    case (m_code)
      0:          if (ini) n = 1;
      1:          begin m_wait = 0; n = 2; end
      2: begin
        if (jog)                 n = 4;
        else if (m_wait >= TO-1) n = 13;
        m_wait = m_wait + 1;
      end
      4:          n = 5;
      5:          n = !ig ? 14 : (f ? 10 : 6);
      6:          begin m_wait = 0; n = 2; end
      10, 13, 14: if (ini) n = 1;
      default:    n = 0;
    endcase
    m_code = n;
    m_db   = jog;
  endtask

  task automatic tick(input logic ini, input logic jog, input logic f, input logic ig);
    iniciar = ini;
    jogada  = jog;
    fim     = f;
    igual   = ig;
    @(posedge clock);
    model_step(ini, jog, f, ig);
    #1;
  endtask

  task automatic do_play(input int gap, input logic f, input logic ig, input string tag);
    for (int i = 0; i < gap + 4; i++) begin
      tick(1'b0, i == gap, f, ig);
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL %s cyc%0d obs=%h exp=%h", tag, i, obs, exp_obs());
      end
    end
  endtask

  task automatic start_game(input int n_ini, input string tag);
    for (int i = 0; i < n_ini; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL %s obs=%h exp=%h", tag, obs, exp_obs());
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    iniciar = 0; jogada = 0; fim = 0; igual = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs obs=%h exp=%h", obs, 13'h0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL idle_inicial obs=%h exp=%h", obs, exp_obs());
      end
    end
  endtask

  task automatic test_acerto();
    do_reset();
    start_game(5, "acerto_start");
    for (int p = 0; p < 16; p++) do_play($urandom_range(0, 6), p == 15, 1'b1, "acerto_play");
    checks++;
    if ({db_estado, acertou, pronto, errou} !== {4'hA, 3'b110}) begin
      errors++;
      $display("FAIL acerto_final got=%h want=%h", {db_estado, acertou, pronto, errou}, {4'hA, 3'b110});
    end
  endtask

  task automatic test_erro();
    do_reset();
    start_game(1, "erro_start");
    for (int p = 0; p < 3; p++) do_play($urandom_range(0, 6), 1'b0, 1'b1, "erro_ok");
    do_play(2, 1'b0, 1'b0, "erro_bad");
    checks++;
    if ({db_estado, errou, acertou} !== {4'hE, 2'b10}) begin
      errors++;
      $display("FAIL erro_final got=%h want=%h", {db_estado, errou, acertou}, {4'hE, 2'b10});
    end
  endtask

  task automatic wait_timeout(input string tag);
    int n;
    n = 0;
    while (db_estado == 4'h2 && n < 4000) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL %s cyc%0d obs=%h exp=%h", tag, n, obs, exp_obs());
      end
    end
    checks++;
    if (n !== TO || db_estado !== 4'hD || {timeout, errou, pronto} !== 3'b111) begin
      errors++;
      $display("FAIL %s_len got=%0d st=%h want=%0d st=d", tag, n, db_estado, TO);
    end
  endtask

  // continues from FIM_ERRO left by test_erro
  task automatic test_restart();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({db_estado, zeraC, zeraR} !== {4'h1, 2'b11}) begin
      errors++;
      $display("FAIL restart_prep got=%h want=%h", {db_estado, zeraC, zeraR}, {4'h1, 2'b11});
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_obs() || db_estado !== 4'h2) begin
      errors++;
      $display("FAIL restart_espera obs=%h exp=%h", obs, exp_obs());
    end
    wait_timeout("restart_timer");
  endtask

  task automatic test_timeout();
    do_reset();
    start_game(2, "to_start");
    for (int p = 0; p < 3; p++) do_play($urandom_range(0, 6), 1'b0, 1'b1, "to_ok");
    wait_timeout("timeout");
  endtask

  task automatic test_jogada_on_expiry();
    do_reset();
    start_game(1, "exp_start");
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (db_estado !== 4'h2 || obs !== exp_obs()) begin
      errors++;
      $display("FAIL expiry_pre obs=%h exp=%h", obs, exp_obs());
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (db_estado !== 4'h4 || timeout !== 1'b0 || obs !== exp_obs()) begin
      errors++;
      $display("FAIL expiry_jogada obs=%h exp=%h", obs, exp_obs());
    end
  endtask

  task automatic test_reset_mid_game();
    do_reset();
    start_game(1, "mid_start");
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (db_estado !== 4'h5) begin
      errors++;
      $display("FAIL mid_comparacao got=%h want=5", db_estado);
    end
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL mid_async_reset obs=%h exp=%h", obs, 13'h0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL mid_abandon obs=%h exp=%h", obs, exp_obs());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0);
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL random cyc%0d obs=%h exp=%h", i, obs, exp_obs());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acerto();
    test_erro();
    test_restart();
    test_timeout();
    test_jogada_on_expiry();
    test_reset_mid_game();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_jogada_timeout.md
CONTROLE_JOGADA_TIMEOUT -- requirements
Module: controle_jogada_timeout

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 3000: clock cycles allowed in ESPERA before timeout (3 s at 1 kHz).
REQ-002 SHALL have parameter TIMER_W, default 12: timeout counter width; TIMER_W SHALL satisfy 2^TIMER_W >= TIMEOUT_CYCLES.
REQ-003 SHALL have clock, input, 1: single system clock; all state updates occur on its rising edge.
REQ-004 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have iniciar, input, 1: level request to start or restart a game.
REQ-006 SHALL have jogada, input, 1: one-cycle pulse from the datapath edge detector when a play is made on chaves.
REQ-007 SHALL have fim, input, 1: datapath address counter is at its last position.
REQ-008 SHALL have igual, input, 1: registered play equals the memory word.
REQ-009 SHALL have zeraC, contaC, zeraR, registraR, outputs, 1 each: datapath counter and register controls.
REQ-010 SHALL have acertou, errou, pronto, timeout, outputs, 1 each: game result flags.
REQ-011 SHALL have db_tem_jogada, output, 1: registered copy of jogada, for debug.
REQ-012 SHALL have db_estado, output, 4: current state code.

Function
REQ-013 SHALL be a Moore FSM; every output SHALL depend only on the current state, except db_tem_jogada.
REQ-014 SHALL use state codes INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=4, COMPARACAO=5, PROXIMO=6, FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=D.
REQ-015 SHALL transition INICIAL->PREPARACAO when iniciar=1; otherwise SHALL remain in INICIAL.
REQ-016 SHALL transition PREPARACAO->ESPERA unconditionally; in PREPARACAO: zeraC=1, zeraR=1, timer cleared.
REQ-017 SHALL, in ESPERA, increment the timer each cycle; jogada=1 SHALL go to REGISTRA; timer==TIMEOUT_CYCLES-1 with jogada=0 SHALL go to FIM_TIMEOUT.
REQ-018 SHALL give jogada priority when jogada and timeout expiry occur in the same cycle.
REQ-019 SHALL assert registraR=1 in REGISTRA and then go to COMPARACAO.
REQ-020 SHALL, in COMPARACAO, go to FIM_ERRO when igual=0, to FIM_ACERTO when igual=1 and fim=1, and to PROXIMO when igual=1 and fim=0.
REQ-021 SHALL, in PROXIMO: contaC=1, timer cleared, next state ESPERA.
REQ-022 SHALL assert pronto=1 in FIM_ACERTO, FIM_ERRO and FIM_TIMEOUT.
REQ-023 SHALL assert acertou=1 only in FIM_ACERTO.
REQ-024 SHALL assert errou=1 in FIM_ERRO and in FIM_TIMEOUT.
REQ-025 SHALL assert timeout=1 only in FIM_TIMEOUT.
REQ-026 SHALL hold result flags while in a final state; iniciar=1 in any final state SHALL go to PREPARACAO.
REQ-027 SHALL ignore iniciar in every non-final state.
REQ-028 SHALL ignore jogada outside ESPERA.
REQ-029 SHALL hold the timer, without wrapping, outside ESPERA.
REQ-030 SHALL send any unused state code to INICIAL on the next clock.
REQ-031 SHALL have latency jogada -> COMPARACAO of 2 clocks; a play SHALL never be double-registered.

Reset
REQ-032 SHALL, on reset=1, immediately (asynchronously) force state INICIAL, timer=0, db_tem_jogada=0.
REQ-033 SHALL, in INICIAL, drive all control and result outputs to 0 and db_estado to 0.
REQ-034 SHALL, on reset mid-game, abandon the game; restart SHALL require iniciar.

Structure
REQ-035 SHALL take state codes and TIMEOUT_CYCLES default from the shared exp4 constants include/package, which the datapath debug decoders also use.
REQ-036 SHALL implement the timer as sub-module temporizador_timeout (inputs zera, conta; output fim_tempo).

Verification
REQ-037 SHALL cover: reset, iniciar 5 cycles, 16 plays each followed by igual=1 (fim=1 on the last) -> FIM_ACERTO, acertou=1, pronto=1, db_estado=A.
REQ-038 SHALL cover: 3 correct plays, then 4th play with igual=0 -> FIM_ERRO, errou=1, acertou=0, db_estado=E.
REQ-039 SHALL cover: 3 correct plays, then no jogada for 4000 cycles -> FIM_TIMEOUT exactly 3000 cycles after entering ESPERA, with timeout=1, errou=1, db_estado=D.
REQ-040 SHALL cover: jogada pulse on the expiry cycle -> REGISTRA entered, timeout stays 0.
REQ-041 SHALL cover: reset asserted in COMPARACAO -> db_estado=0 before the next edge and all outputs 0.
REQ-042 SHALL cover: iniciar=1 in FIM_ERRO -> PREPARACAO with zeraC=1, then ESPERA with the timer restarted from 0.
